// File: rtl/apb_node_pkg.sv
// Shared types and constants for the watchdog-supervised APB node.
// FSM encoding, default error data and index-width helper.
package apb_node_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DSETUP,
    DACCESS,
    RESP
  } state_e;

  localparam logic [31:0] ERR_DATA_DEF = 32'hBADC0FFE;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_node_wd_if.sv
// Upstream APB slave port and downstream APB master ports of the node.
// The slave modport is the node's view; master is the environment's view.
interface apb_node_wd_if #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NUM_SLAVES     = 8
);

  logic                      psel_i;
  logic                      penable_i;
  logic                      pwrite_i;
  logic [APB_ADDR_WIDTH-1:0] paddr_i;
  logic [31:0]               pwdata_i;
  logic [31:0]               prdata_o;
  logic                      pready_o;
  logic                      pslverr_o;

  logic [NUM_SLAVES-1:0]     m_psel_o;
  logic                      m_penable_o;
  logic                      m_pwrite_o;
  logic [APB_ADDR_WIDTH-1:0] m_paddr_o;
  logic [31:0]               m_pwdata_o;
  logic [NUM_SLAVES*32-1:0]  m_prdata_i;
  logic [NUM_SLAVES-1:0]     m_pready_i;
  logic [NUM_SLAVES-1:0]     m_pslverr_i;

  modport slave (
    input  psel_i, penable_i, pwrite_i,
    input  paddr_i, pwdata_i,
    output prdata_o, pready_o, pslverr_o,
    output m_psel_o, m_penable_o, m_pwrite_o,
    output m_paddr_o, m_pwdata_o,
    input  m_prdata_i, m_pready_i, m_pslverr_i
  );

  modport master (
    output psel_i, penable_i, pwrite_i,
    output paddr_i, pwdata_i,
    input  prdata_o, pready_o, pslverr_o,
    input  m_psel_o, m_penable_o, m_pwrite_o,
    input  m_paddr_o, m_pwdata_o,
    output m_prdata_i, m_pready_i, m_pslverr_i
  );

endinterface

// File: rtl/apb_node_wdog.sv
// Access-phase watchdog: clear, count up, flag terminal count.
// A zero limit keeps the terminal-count flag permanently low.
module apb_node_wdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam int CW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o = (TIMEOUT_CYCLES != 0) &&
                (cnt_q == CW'(TIMEOUT_CYCLES));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !tc_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_node_wd.sv
// APB node: address decode, registered downstream re-timing and
// watchdog abort of hung slaves; decode misses answer with an error.
module apb_node_wd
  import apb_node_pkg::*;
#(
  parameter int          APB_ADDR_WIDTH   = 12,
  parameter int          NUM_SLAVES       = 8,
  parameter int          SLAVE_ADDR_WIDTH = 8,
  parameter int          TIMEOUT_CYCLES   = 255,
  parameter logic [31:0] ERR_DATA         = ERR_DATA_DEF
) (
  input  logic         clk_i,
  input  logic         rst_n,
  apb_node_wd_if.slave bus,
  output logic         timeout_o,
  output logic [3:0]   err_idx_o,
  output logic         miss_o
);

  localparam int IDX_W = idx_w(NUM_SLAVES);
  localparam int HI    = SLAVE_ADDR_WIDTH + IDX_W;

  state_e                    state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]               wdata_q, wdata_d;
  logic                      wr_q, wr_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [31:0]               rdata_q, rdata_d;
  logic                      err_q, err_d;
  logic                      to_q, to_d;
  logic                      miss_q, miss_d;
  logic [3:0]                eidx_q, eidx_d;

  logic [IDX_W-1:0]      a_idx;
  logic                  a_hit;
  logic                  setup;
  logic [NUM_SLAVES-1:0] sel_oh;
  logic [31:0]           rd_sel;
  logic                  rdy_sel;
  logic                  slverr_sel;
  logic                  wd_clr, wd_inc, wd_tc;

  assign a_idx = bus.paddr_i[SLAVE_ADDR_WIDTH +: IDX_W];
  assign a_hit = (32'(a_idx) < 32'(NUM_SLAVES)) &&
                 ((bus.paddr_i >> HI) == '0);
  assign setup = bus.psel_i && !bus.penable_i;

  assign rd_sel     = bus.m_prdata_i[{idx_q, 5'd0} +: 32];
  assign rdy_sel    = bus.m_pready_i[idx_q];
  assign slverr_sel = bus.m_pslverr_i[idx_q];

  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel_oh[i] = (idx_q == IDX_W'(i));
    end
  end

  apb_node_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk_i(clk_i),
    .rst_n(rst_n),
    .clr_i(wd_clr),
    .inc_i(wd_inc),
    .tc_o (wd_tc)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    to_d    = 1'b0;
    miss_d  = 1'b0;
    eidx_d  = eidx_q;
    wd_clr  = 1'b0;
    wd_inc  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (setup) begin
          addr_d  = bus.paddr_i;
          wdata_d = bus.pwdata_i;
          wr_d    = bus.pwrite_i;
          idx_d   = a_idx;
          if (a_hit) begin
            state_d = DSETUP;
            wd_clr  = 1'b1;
          end else begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = ERR_DATA;
            miss_d  = 1'b1;
          end
        end
      end
      DSETUP: state_d = DACCESS;
      DACCESS: begin
        // ready beats the watchdog when both land on the same cycle
        if (rdy_sel) begin
          state_d = RESP;
          rdata_d = wr_q ? 32'h0 : rd_sel;
          err_d   = slverr_sel;
        end else if (wd_tc) begin
          state_d = RESP;
          rdata_d = ERR_DATA;
          err_d   = 1'b1;
          to_d    = 1'b1;
          eidx_d  = 4'(idx_q);
        end else begin
          wd_inc = 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      miss_q  <= 1'b0;
      eidx_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      to_q    <= to_d;
      miss_q  <= miss_d;
      eidx_q  <= eidx_d;
    end
  end

  assign bus.m_psel_o =
    (state_q == DSETUP || state_q == DACCESS) ? sel_oh : '0;
  assign bus.m_penable_o = (state_q == DACCESS);
  assign bus.m_pwrite_o  = wr_q;
  assign bus.m_paddr_o   = addr_q;
  assign bus.m_pwdata_o  = wdata_q;

  assign bus.pready_o  = (state_q == RESP);
  assign bus.prdata_o  = bus.pready_o ? rdata_q : 32'h0;
  assign bus.pslverr_o = bus.pready_o & err_q;

  assign timeout_o = to_q;
  assign miss_o    = miss_q;
  assign err_idx_o = eidx_q;

endmodule

// File: tb/tb_apb_node_wd.sv
// Scoreboard bench for apb_node_wd: 6 slaves, 4-cycle watchdog.
// Driver pushes expected responses, a monitor pops and compares.
module tb_apb_node_wd;

  localparam int NS = 6;
  localparam int T  = 4;
  localparam logic [31:0] ERRD = 32'hBADC0FFE;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       timeout;
  logic       miss;
  logic [3:0] eidx;

  always #5 clk = ~clk;

  apb_node_wd_if #(.APB_ADDR_WIDTH(12), .NUM_SLAVES(NS)) bus ();

  apb_node_wd #(
    .APB_ADDR_WIDTH  (12),
    .NUM_SLAVES      (NS),
    .SLAVE_ADDR_WIDTH(8),
    .TIMEOUT_CYCLES  (T),
    .ERR_DATA        (ERRD)
  ) dut (
    .clk_i    (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .timeout_o(timeout),
    .err_idx_o(eidx),
    .miss_o   (miss)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    logic        to;
    logic        ms;
    logic [3:0]  eidx;
    int          t0;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acck = 0;
  int cur_tgt = 0;
  int cur_w = 0;
  logic [NS-1:0] cur_oh = '0;
  logic [11:0]   cur_addr = '0;
  logic          cur_wr = 1'b0;
  logic [31:0]   cur_wdata = '0;
  logic [3:0]    m_eidx = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp,
               $time);
    end
  endtask

  // slave model: target answers after cur_w wait states, others idle-ready
  always @(negedge clk) begin : responder
    logic [NS-1:0] v;
    v = '1;
    if (bus.m_penable_o && (|bus.m_psel_o)) begin
      if (cur_tgt < NS) v[cur_tgt] = (acck == cur_w);
      acck++;
    end else begin
      if (cur_tgt < NS) v[cur_tgt] = 1'b0;
      acck = 0;
    end
    bus.m_pready_i = v;
  end

  always @(negedge clk) begin : monitor
    if (rst_n) begin
      if (!bus.m_penable_o && (bus.m_psel_o != '0)) begin
        chk("dsetup_psel", 32'(bus.m_psel_o), 32'(cur_oh));
        chk("dsetup_paddr", 32'(bus.m_paddr_o), 32'(cur_addr));
        chk("dsetup_pwrite", 32'(bus.m_pwrite_o), 32'(cur_wr));
        chk("dsetup_pwdata", bus.m_pwdata_o, cur_wdata);
      end
      if (bus.pready_o) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pready: got 1 expected 0");
        end else begin
          mon_e = q.pop_front();
          chk("prdata", bus.prdata_o, mon_e.data);
          chk("pslverr", 32'(bus.pslverr_o), 32'(mon_e.err));
          chk("latency", 32'(cyc - mon_e.t0), 32'(mon_e.lat));
          chk("timeout", 32'(timeout), 32'(mon_e.to));
          chk("miss", 32'(miss), 32'(mon_e.ms));
          chk("err_idx", 32'(eidx), 32'(mon_e.eidx));
          chk("resp_psel", 32'(bus.m_psel_o), 32'h0);
        end
      end else begin
        chk("quiet_prdata", bus.prdata_o, 32'h0);
        chk("quiet_flags",
            {29'h0, bus.pslverr_o, timeout, miss}, 32'h0);
      end
    end
  end

  task automatic xfer(input logic [11:0] a, input logic wr,
                      input int w, input bit drop,
                      input logic [31:0] rd, input logic serr);
    exp_t e;
    int   idx;
    int   n;
    @(negedge clk);
    idx = int'(a >> 8);
    for (int i = 0; i < NS; i++) bus.m_prdata_i[i*32 +: 32] = $urandom;
    bus.m_pslverr_i = NS'($urandom);
    if (idx < NS) begin
      bus.m_prdata_i[idx*32 +: 32] = rd;
      bus.m_pslverr_i[idx] = serr;
    end
    cur_tgt = idx;
    cur_w = w;
    cur_oh = (idx < NS) ? NS'(1 << idx) : '0;
    cur_addr = a;
    cur_wr = wr;
    cur_wdata = $urandom;
    bus.psel_i = 1'b1;
    bus.penable_i = 1'b0;
    bus.paddr_i = a;
    bus.pwrite_i = wr;
    bus.pwdata_i = cur_wdata;
    e.t0 = cyc;
    e.to = 1'b0;
    e.ms = 1'b0;
    if (idx >= NS) begin
      e.data = ERRD; e.err = 1'b1; e.lat = 1; e.ms = 1'b1;
    end else if (w <= T) begin
      e.data = wr ? 32'h0 : rd; e.err = serr; e.lat = 3 + w;
    end else begin
      e.data = ERRD; e.err = 1'b1; e.lat = 3 + T; e.to = 1'b1;
      m_eidx = 4'(idx);
    end
    e.eidx = m_eidx;
    q.push_back(e);
    @(negedge clk);
    if (drop) bus.psel_i = 1'b0;
    else bus.penable_i = 1'b1;
    n = 0;
    while (!bus.pready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.pready_o) begin
      checks++;
      errors++;
      $display("FAIL no_pready: addr %h got none expected within 20", a);
      q.delete();
    end
    if (drop) bus.penable_i = 1'b0;
  endtask

  initial begin
    logic [11:0] ra;
    int r;
    bus.psel_i = 1'b0;
    bus.penable_i = 1'b0;
    bus.pwrite_i = 1'b0;
    bus.paddr_i = '0;
    bus.pwdata_i = '0;
    bus.m_prdata_i = '0;
    bus.m_pslverr_i = '0;
    bus.m_pready_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_pready", 32'(bus.pready_o), 32'h0);
    chk("rst_psel", 32'(bus.m_psel_o), 32'h0);
    chk("rst_paddr", 32'(bus.m_paddr_o), 32'h0);
    chk("rst_err_idx", 32'(eidx), 32'h0);
    rst_n = 1'b1;

    xfer(12'h304, 1'b0, 0, 1'b0, 32'h12345678, 1'b0);
    xfer(12'h010, 1'b1, 3, 1'b0, 32'h5555AAAA, 1'b0);
    xfer(12'h5A0, 1'b0, 99, 1'b0, 32'h01020304, 1'b0);
    xfer(12'h700, 1'b0, 0, 1'b0, 32'h0, 1'b0);
    xfer(12'h800, 1'b1, 0, 1'b0, 32'h0, 1'b0);
    xfer(12'h6FF, 1'b0, 0, 1'b0, 32'h0, 1'b0);
    xfer(12'h2C8, 1'b0, T, 1'b0, 32'hCAFEF00D, 1'b0);
    xfer(12'h2C8, 1'b0, T + 1, 1'b0, 32'hCAFEF00D, 1'b0);
    xfer(12'h1F0, 1'b0, 1, 1'b0, 32'hA5A5A5A5, 1'b1);
    xfer(12'h404, 1'b0, 2, 1'b1, 32'h44440404, 1'b0);

    // reset while the downstream access phase is waiting
    @(negedge clk);
    cur_tgt = 2; cur_w = 99; cur_oh = NS'(1 << 2);
    cur_addr = 12'h210; cur_wr = 1'b0; cur_wdata = 32'h0;
    bus.paddr_i = 12'h210; bus.pwrite_i = 1'b0; bus.pwdata_i = 32'h0;
    bus.psel_i = 1'b1; bus.penable_i = 1'b0;
    @(negedge clk);
    bus.penable_i = 1'b1;
    @(negedge clk);
    chk("pre_rst_penable", 32'(bus.m_penable_o), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_psel", 32'(bus.m_psel_o), 32'h0);
    chk("arst_ctl", {28'h0, bus.m_penable_o, bus.m_pwrite_o,
                     bus.pready_o, bus.pslverr_o}, 32'h0);
    chk("arst_paddr", 32'(bus.m_paddr_o), 32'h0);
    chk("arst_prdata", bus.prdata_o, 32'h0);
    chk("arst_flags", {29'h0, timeout, miss, 1'b0}, 32'h0);
    chk("arst_err_idx", 32'(eidx), 32'h0);
    m_eidx = '0;
    bus.psel_i = 1'b0;
    bus.penable_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    xfer(12'h1A4, 1'b0, 0, 1'b0, 32'h0BADBEEF, 1'b0);

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 4) != 0)
        ra = {4'($urandom_range(0, NS - 1)), 8'($urandom)};
      else
        ra = 12'($urandom);
      r = int'($urandom_range(0, 7));
      xfer(ra, 1'($urandom), (r == 7) ? 99 : r,
           ($urandom_range(0, 9) == 0), $urandom, 1'($urandom));
    end

    @(negedge clk);
    bus.psel_i = 1'b0;
    bus.penable_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
